// File: rtl/reception_pkg.sv
// rtl/reception_pkg.sv - shared reception-desk encodings for messages, queries and doctor codes
package reception_pkg;

  localparam logic [1:0] MSG_NONE = 2'd0;
  localparam logic [1:0] MSG_A    = 2'd1;
  localparam logic [1:0] MSG_B    = 2'd2;
  localparam logic [1:0] MSG_WAIT = 2'd3;

  localparam logic [1:0] Q_A   = 2'b00;
  localparam logic [1:0] Q_B   = 2'b01;
  localparam logic [1:0] Q_ANY = 2'b10;

  localparam logic [1:0] DOC_NONE = 2'd0;
  localparam logic [1:0] DOC_A    = 2'd1;
  localparam logic [1:0] DOC_B    = 2'd2;

  // Any query with the upper bit set accepts either doctor.
  function automatic logic query_is_any(input logic [1:0] q);
    return q[1];
  endfunction

endpackage

// File: rtl/consult_timer.sv
// rtl/consult_timer.sv - per-doctor consultation countdown; busy for CONSULT_CYCLES after each load
module consult_timer #(
  parameter int CONSULT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  output logic busy
);

  localparam int TW = $clog2(CONSULT_CYCLES + 1);

  logic [TW-1:0] cnt_q, cnt_d;
  logic          busy_q;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = TW'(CONSULT_CYCLES);
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - TW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      busy_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      busy_q <= (cnt_d != '0);
    end
  end

  assign busy = busy_q;

endmodule

// File: rtl/patient_wait_queue.sv
// rtl/patient_wait_queue.sv - waiting-patient FIFO, doctor timers and oldest-first dispatch
// Optional macro QUEUE_STATS_EN adds served_cnt and peak_cnt outputs.
module patient_wait_queue
  import reception_pkg::*;
#(
  parameter int  DEPTH          = 8,
  parameter int  CONSULT_CYCLES = 15,
  localparam int CW             = $clog2(DEPTH + 1),
  localparam int PW             = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    query,
  input  logic [1:0]    message,
  output logic          doc_a_busy,
  output logic          doc_b_busy,
  output logic          disp_valid,
  output logic [1:0]    disp_doctor,
  output logic [1:0]    disp_query,
  output logic [CW-1:0] q_count,
  output logic          q_full,
  output logic          q_empty,
  output logic          overflow
`ifdef QUEUE_STATS_EN
  ,
  output logic [15:0]   served_cnt,
  output logic [CW-1:0] peak_cnt
`endif
);

  logic [1:0]    mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, empty_q, disp_valid_q, overflow_q;
  logic [1:0]    disp_doctor_q, disp_query_q;

  logic          desk_a, desk_b, desk_wait;
  logic          a_ok, b_ok, pop, push, drop;
  logic [1:0]    head_query, pick;

  assign desk_a     = start && (message == MSG_A);
  assign desk_b     = start && (message == MSG_B);
  assign desk_wait  = start && (message == MSG_WAIT);
  assign head_query = mem_q[rd_ptr_q];

  // A doctor the desk is loading this cycle is not available to the queue.
  assign a_ok = !doc_a_busy && !desk_a;
  assign b_ok = !doc_b_busy && !desk_b;

  always_comb begin
    pick = DOC_NONE;
    if (count_q != '0) begin
      if (query_is_any(head_query)) begin
        pick = a_ok ? DOC_A : (b_ok ? DOC_B : DOC_NONE);
      end else if (head_query == Q_A) begin
        pick = a_ok ? DOC_A : DOC_NONE;
      end else begin
        pick = b_ok ? DOC_B : DOC_NONE;
      end
    end
  end

  assign pop  = (pick != DOC_NONE);
  assign push = desk_wait && ((count_q != CW'(DEPTH)) || pop);
  assign drop = desk_wait && (count_q == CW'(DEPTH)) && !pop;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
  end

  consult_timer #(.CONSULT_CYCLES(CONSULT_CYCLES)) u_timer_a (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (desk_a || (pick == DOC_A)),
    .busy  (doc_a_busy)
  );

  consult_timer #(.CONSULT_CYCLES(CONSULT_CYCLES)) u_timer_b (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (desk_b || (pick == DOC_B)),
    .busy  (doc_b_busy)
  );

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= query;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      full_q        <= 1'b0;
      empty_q       <= 1'b1;
      disp_valid_q  <= 1'b0;
      disp_doctor_q <= DOC_NONE;
      disp_query_q  <= 2'b00;
      overflow_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q       <= count_d;
      full_q        <= (count_d == CW'(DEPTH));
      empty_q       <= (count_d == '0);
      disp_valid_q  <= pop;
      disp_doctor_q <= pick;
      disp_query_q  <= pop ? head_query : 2'b00;
      overflow_q    <= drop;
    end
  end

  assign q_count     = count_q;
  assign q_full      = full_q;
  assign q_empty     = empty_q;
  assign disp_valid  = disp_valid_q;
  assign disp_doctor = disp_doctor_q;
  assign disp_query  = disp_query_q;
  assign overflow    = overflow_q;

`ifdef QUEUE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      served_cnt <= '0;
      peak_cnt   <= '0;
    end else begin
      if (pop && (served_cnt != 16'hFFFF)) served_cnt <= served_cnt + 16'd1;
      if (count_d > peak_cnt) peak_cnt <= count_d;
    end
  end
`endif

endmodule

// File: tb/tb_patient_wait_queue.sv
// tb/tb_patient_wait_queue.sv - directed scoreboard bench for patient_wait_queue
module tb_patient_wait_queue;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [1:0] query = 2'b00;
  logic [1:0] message = 2'b00;
  logic       doc_a_busy, doc_b_busy, disp_valid, q_full, q_empty, overflow;
  logic [1:0] disp_doctor, disp_query;
  logic [3:0] q_count;
`ifdef QUEUE_STATS_EN
  logic [15:0] served_cnt;
  logic [3:0]  peak_cnt;
`endif

  int         nchecks = 0;
  int         nerr = 0;
  int         n_exp_total = 0;
  logic [3:0] exp_q[$];
  logic [3:0] sb_e;

  patient_wait_queue #(.DEPTH(8), .CONSULT_CYCLES(15)) dut (
`ifdef QUEUE_STATS_EN
    .served_cnt  (served_cnt),
    .peak_cnt    (peak_cnt),
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .query       (query),
    .message     (message),
    .doc_a_busy  (doc_a_busy),
    .doc_b_busy  (doc_b_busy),
    .disp_valid  (disp_valid),
    .disp_doctor (disp_doctor),
    .disp_query  (disp_query),
    .q_count     (q_count),
    .q_full      (q_full),
    .q_empty     (q_empty),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nchecks++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic desk(input logic [1:0] m, input logic [1:0] q);
    start   = 1'b1;
    message = m;
    query   = q;
    step();
    start   = 1'b0;
    message = 2'd0;
    query   = 2'd0;
  endtask

  task automatic expect_disp(input logic [1:0] doc, input logic [1:0] q);
    exp_q.push_back({doc, q});
    n_exp_total++;
  endtask

  task automatic wait_low(input int which, input string nm);
    int n = 0;
    while (((which == 0) ? doc_a_busy : doc_b_busy) && n < 60) begin
      step();
      n++;
    end
    chk(nm, (which == 0) ? doc_a_busy : doc_b_busy, 0);
  endtask

  task automatic wait_free(input string nm);
    int n = 0;
    while ((doc_a_busy || doc_b_busy) && n < 60) begin
      step();
      n++;
    end
    chk(nm, {doc_a_busy, doc_b_busy}, 0);
  endtask

  task automatic measure_a(output int n);
    n = 0;
    while (doc_a_busy && n < 40) begin
      n++;
      step();
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && disp_valid) begin
      if (exp_q.size() == 0) begin
        nchecks++;
        nerr++;
        $display("FAIL unexpected_dispatch: got doctor=%0d query=%0d expected no dispatch",
                 disp_doctor, disp_query);
      end else begin
        sb_e = exp_q.pop_front();
        chk("disp_doctor", disp_doctor, sb_e[3:2]);
        chk("disp_query", disp_query, sb_e[1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    step();
    chk("rst_q_empty", q_empty, 1);
    chk("rst_q_count", q_count, 0);
    chk("rst_q_full", q_full, 0);
    chk("rst_busy", {doc_a_busy, doc_b_busy}, 0);
    chk("rst_disp", {disp_valid, disp_doctor, disp_query}, 0);
    chk("rst_overflow", overflow, 0);

    // desk allots A: busy exactly 15 cycles
    desk(2'd1, 2'b00);
    measure_a(n);
    chk("t2_a_busy_len", n, 15);
    chk("t2_a_low", doc_a_busy, 0);
    chk("t2_b_idle", doc_b_busy, 0);

    // waiting patient for A dispatched the cycle after A frees
    wait_free("t3_free");
    desk(2'd1, 2'b00);
    expect_disp(2'd1, 2'b00);
    desk(2'd3, 2'b00);
    chk("t3_q_count", q_count, 1);
    wait_low(0, "t3_a_free");
    chk("t3_no_early_disp", disp_valid, 0);
    chk("t3_q_held", q_count, 1);
    step();
    chk("t3_disp_valid", disp_valid, 1);
    chk("t3_a_reloaded", doc_a_busy, 1);
    chk("t3_q_popped", q_count, 0);
    measure_a(n);
    chk("t3_a_busy_len", n, 15);

    // head blocked on A stalls queue although B is free
    wait_free("t4_free");
    desk(2'd2, 2'b00);
    repeat (3) step();
    desk(2'd1, 2'b00);
    expect_disp(2'd1, 2'b00);
    desk(2'd3, 2'b00);
    expect_disp(2'd2, 2'b01);
    desk(2'd3, 2'b01);
    wait_low(1, "t4_b_free");
    chk("t4_a_still_busy", doc_a_busy, 1);
    chk("t4_head_blocked", disp_valid, 0);
    chk("t4_q_count2", q_count, 2);
    wait_low(0, "t4_a_free");
    chk("t4_no_disp_yet", disp_valid, 0);
    step();
    chk("t4_disp1", disp_valid, 1);
    step();
    chk("t4_disp2", disp_valid, 1);
    chk("t4_q_empty", q_empty, 1);

    // either-doctor query: A preferred, B when A busy
    wait_free("t5_free");
    expect_disp(2'd1, 2'b11);
    desk(2'd3, 2'b11);
    chk("t5_q_count", q_count, 1);
    step();
    chk("t5_disp_a", disp_valid, 1);
    chk("t5_a_busy", doc_a_busy, 1);
    expect_disp(2'd2, 2'b11);
    desk(2'd3, 2'b11);
    chk("t5_gap", disp_valid, 0);
    step();
    chk("t5_disp_b", disp_valid, 1);
    chk("t5_b_busy", doc_b_busy, 1);

    // fill, overflow, push on dispatch edge while full, drain
    wait_free("t6_free");
    desk(2'd1, 2'b00);
    desk(2'd2, 2'b00);
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0) begin
        expect_disp(2'd1, 2'b00);
        desk(2'd3, 2'b00);
      end else begin
        expect_disp(2'd2, 2'b01);
        desk(2'd3, 2'b01);
      end
    end
    chk("t6_count8", q_count, 8);
    chk("t6_full", q_full, 1);
    desk(2'd3, 2'b01);
    chk("t6_overflow", overflow, 1);
    chk("t6_count_held", q_count, 8);
    step();
    chk("t6_overflow_pulse", overflow, 0);
    wait_low(0, "t6_a_free");
    chk("t6_still_full", q_count, 8);
    expect_disp(2'd1, 2'b00);
    desk(2'd3, 2'b00);
    chk("t6_disp_on_push", disp_valid, 1);
    chk("t6_count_push_pop", q_count, 8);
    chk("t6_no_overflow", overflow, 0);
    n = 0;
    while (!q_empty && n < 600) begin
      step();
      n++;
    end
    chk("t6_drained", q_empty, 1);
    step();
`ifdef QUEUE_STATS_EN
    chk("stats_served", served_cnt, n_exp_total);
    chk("stats_peak", peak_cnt, 8);
`endif

    // reset mid-run with entries queued
    wait_free("t1_free");
    desk(2'd1, 2'b00);
    desk(2'd2, 2'b00);
    desk(2'd3, 2'b00);
    desk(2'd3, 2'b01);
    desk(2'd3, 2'b11);
    chk("t1_count3", q_count, 3);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t1_rst_count", q_count, 0);
    chk("t1_rst_empty", q_empty, 1);
    chk("t1_rst_busy", {doc_a_busy, doc_b_busy}, 0);
    chk("t1_rst_disp", disp_valid, 0);
`ifdef QUEUE_STATS_EN
    chk("t1_rst_stats", {served_cnt, peak_cnt}, 0);
`endif
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (20) step();
    chk("t1_still_empty", q_empty, 1);
    chk("sb_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
